// File: rtl/icache_miss_ctrl.sv
// icache miss handler: one outstanding miss, line-aligned downstream read,
// multi-beat refill assembly, data-array write and requester response.
module icache_miss_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int TXNID_WIDTH = 8,
  parameter int INDEX_WIDTH = 6,
  parameter int LINE_WIDTH  = 512,
  parameter int BEAT_WIDTH  = 128,
  parameter int WAY_NUM     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   miss_vld,
  output logic                   miss_rdy,
  input  logic [ADDR_WIDTH-1:0]  miss_addr,
  input  logic [TXNID_WIDTH-1:0] miss_txnid,
  input  logic                   miss_way,
  output logic                   dn_req_vld,
  input  logic                   dn_req_rdy,
  output logic [ADDR_WIDTH-1:0]  dn_req_addr,
  output logic [TXNID_WIDTH-1:0] dn_req_txnid,
  input  logic                   dn_rsp_vld,
  input  logic [BEAT_WIDTH-1:0]  dn_rsp_data,
  input  logic                   dn_rsp_last,
  output logic                   data_wr_en,
  output logic                   data_wr_way,
  output logic [INDEX_WIDTH-1:0] data_wr_index,
  output logic [LINE_WIDTH-1:0]  data_wr_data,
  output logic                   up_rsp_vld,
  input  logic                   up_rsp_rdy,
  output logic [TXNID_WIDTH-1:0] up_rsp_txnid,
  output logic [LINE_WIDTH-1:0]  up_rsp_data,
  output logic                   up_rsp_err,
  output logic                   busy
);

  localparam int OFFSET_WIDTH = $clog2(LINE_WIDTH / 8);
  localparam int BEATS        = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W        = $clog2(BEATS);
  localparam int WAY_W        = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
    ADDR_WIDTH'((64'd1 << OFFSET_WIDTH) - 64'd1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    FILL  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [TXNID_WIDTH-1:0] r_txnid;
  logic [WAY_W-1:0]       r_way;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_err;
  logic [LINE_WIDTH-1:0]  r_line;

  logic w_accept;
  logic w_beat;
  logic w_cnt_last;
  logic w_beat_err;

  assign w_accept   = (r_state == IDLE) && miss_vld;
  assign w_beat     = (r_state == FILL) && dn_rsp_vld;
  assign w_cnt_last = (r_cnt == LAST_CNT);
  // A refill must end exactly on the last slot; anything else is an error
  assign w_beat_err = w_beat && (dn_rsp_last != w_cnt_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (miss_vld) w_state_nxt = REQ;
      end
      REQ: begin
        if (dn_req_rdy) w_state_nxt = FILL;
      end
      FILL: begin
        if (dn_rsp_vld && (dn_rsp_last || w_cnt_last)) begin
          if (dn_rsp_last && w_cnt_last) w_state_nxt = WRITE;
          else                           w_state_nxt = RESP;
        end
      end
      WRITE: begin
        w_state_nxt = RESP;
      end
      RESP: begin
        if (up_rsp_rdy) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_txnid <= '0;
      r_way   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_line  <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= miss_addr & ~OFF_MASK;
        r_txnid <= miss_txnid;
        r_way   <= WAY_W'(miss_way);
        r_cnt   <= '0;
        r_err   <= 1'b0;
        r_line  <= '0;
      end
      if (w_beat) begin
        r_line[int'(r_cnt)*BEAT_WIDTH +: BEAT_WIDTH] <= dn_rsp_data;
        if (!w_cnt_last) r_cnt <= r_cnt + CNT_W'(1);
        if (w_beat_err)  r_err <= 1'b1;
      end
    end
  end

  assign miss_rdy      = (r_state == IDLE);
  assign busy          = (r_state != IDLE);
  assign dn_req_vld    = (r_state == REQ);
  assign dn_req_addr   = r_addr;
  assign dn_req_txnid  = r_txnid;
  assign data_wr_en    = (r_state == WRITE);
  assign data_wr_way   = r_way[0];
  assign data_wr_index = r_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign data_wr_data  = r_line;
  assign up_rsp_vld    = (r_state == RESP);
  assign up_rsp_txnid  = r_txnid;
  assign up_rsp_data   = r_line;
  assign up_rsp_err    = r_err;

endmodule

// File: tb/tb_icache_miss_ctrl.sv
// Directed self-checking bench for icache_miss_ctrl.
// Inputs change and outputs are sampled on the falling edge.
module tb_icache_miss_ctrl;

  logic         clk;
  logic         rst;
  logic         miss_vld;
  logic         miss_rdy;
  logic [31:0]  miss_addr;
  logic [7:0]   miss_txnid;
  logic         miss_way;
  logic         dn_req_vld;
  logic         dn_req_rdy;
  logic [31:0]  dn_req_addr;
  logic [7:0]   dn_req_txnid;
  logic         dn_rsp_vld;
  logic [127:0] dn_rsp_data;
  logic         dn_rsp_last;
  logic         data_wr_en;
  logic         data_wr_way;
  logic [5:0]   data_wr_index;
  logic [511:0] data_wr_data;
  logic         up_rsp_vld;
  logic         up_rsp_rdy;
  logic [7:0]   up_rsp_txnid;
  logic [511:0] up_rsp_data;
  logic         up_rsp_err;
  logic         busy;

  int nchk;
  int nerr;

  logic [127:0] b0, b1, b2, b3, bj;

  icache_miss_ctrl dut (
    .clk(clk), .rst(rst),
    .miss_vld(miss_vld), .miss_rdy(miss_rdy),
    .miss_addr(miss_addr), .miss_txnid(miss_txnid),
    .miss_way(miss_way),
    .dn_req_vld(dn_req_vld), .dn_req_rdy(dn_req_rdy),
    .dn_req_addr(dn_req_addr), .dn_req_txnid(dn_req_txnid),
    .dn_rsp_vld(dn_rsp_vld), .dn_rsp_data(dn_rsp_data),
    .dn_rsp_last(dn_rsp_last),
    .data_wr_en(data_wr_en), .data_wr_way(data_wr_way),
    .data_wr_index(data_wr_index), .data_wr_data(data_wr_data),
    .up_rsp_vld(up_rsp_vld), .up_rsp_rdy(up_rsp_rdy),
    .up_rsp_txnid(up_rsp_txnid), .up_rsp_data(up_rsp_data),
    .up_rsp_err(up_rsp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [511:0] got,
                     input logic [511:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue_miss(input logic [31:0] a,
                            input logic [7:0] t,
                            input logic w);
    miss_vld   = 1'b1;
    miss_addr  = a;
    miss_txnid = t;
    miss_way   = w;
    @(negedge clk);
    miss_vld   = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] d, input logic l);
    dn_rsp_vld  = 1'b1;
    dn_rsp_data = d;
    dn_rsp_last = l;
    @(negedge clk);
    dn_rsp_vld  = 1'b0;
    dn_rsp_last = 1'b0;
  endtask

  // Called at the WRITE-state sample point of a good refill.
  task automatic finish_good(input string tag,
                             input logic [511:0] line,
                             input logic w,
                             input logic [5:0] idx,
                             input logic [7:0] t);
    chk({tag, "_wr_en"}, 512'(data_wr_en), 512'd1);
    chk({tag, "_wr_way"}, 512'(data_wr_way), 512'(w));
    chk({tag, "_wr_idx"}, 512'(data_wr_index), 512'(idx));
    chk({tag, "_wr_data"}, data_wr_data, line);
    @(negedge clk);
    chk({tag, "_wr_once"}, 512'(data_wr_en), 512'd0);
    chk({tag, "_rsp_vld"}, 512'(up_rsp_vld), 512'd1);
    chk({tag, "_rsp_txn"}, 512'(up_rsp_txnid), 512'(t));
    chk({tag, "_rsp_err"}, 512'(up_rsp_err), 512'd0);
    chk({tag, "_rsp_data"}, up_rsp_data, line);
    up_rsp_rdy = 1'b1;
    @(negedge clk);
    up_rsp_rdy = 1'b0;
    chk({tag, "_idle_rdy"}, 512'(miss_rdy), 512'd1);
    chk({tag, "_idle_busy"}, 512'(busy), 512'd0);
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    b0 = {16{8'h11}};
    b1 = {16{8'h22}};
    b2 = {16{8'h33}};
    b3 = {16{8'h44}};
    bj = {16{8'hEE}};
    rst = 1'b1;
    miss_vld = 1'b0;
    miss_addr = '0;
    miss_txnid = '0;
    miss_way = 1'b0;
    dn_req_rdy = 1'b0;
    dn_rsp_vld = 1'b0;
    dn_rsp_data = '0;
    dn_rsp_last = 1'b0;
    up_rsp_rdy = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_miss_rdy", 512'(miss_rdy), 512'd1);
    chk("rst_busy", 512'(busy), 512'd0);
    chk("rst_dn_vld", 512'(dn_req_vld), 512'd0);
    chk("rst_wr_en", 512'(data_wr_en), 512'd0);
    chk("rst_up_vld", 512'(up_rsp_vld), 512'd0);
    chk("rst_up_err", 512'(up_rsp_err), 512'd0);
    chk("rst_dn_addr", 512'(dn_req_addr), 512'd0);
    chk("rst_up_data", up_rsp_data, 512'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic miss with zero-wait downstream
    dn_req_rdy = 1'b1;
    issue_miss(32'h0000_1234, 8'h5A, 1'b1);
    chk("t1_dn_vld", 512'(dn_req_vld), 512'd1);
    chk("t1_dn_addr", 512'(dn_req_addr), 512'h0000_1200);
    chk("t1_dn_txn", 512'(dn_req_txnid), 512'h5A);
    chk("t1_busy", 512'(busy), 512'd1);
    @(negedge clk);
    chk("t1_fill_vld", 512'(dn_req_vld), 512'd0);
    send_beat(b0, 1'b0);
    send_beat(b1, 1'b0);
    send_beat(b2, 1'b0);
    send_beat(b3, 1'b1);
    finish_good("t1", {b3, b2, b1, b0}, 1'b1, 6'h08, 8'h5A);

    // Downstream stall with a competing miss
    dn_req_rdy = 1'b0;
    issue_miss(32'hABCD_0047, 8'h33, 1'b0);
    miss_vld   = 1'b1;
    miss_addr  = 32'h9999_0000;
    miss_txnid = 8'h77;
    miss_way   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_dn_vld", 512'(dn_req_vld), 512'd1);
      chk("t2_dn_addr", 512'(dn_req_addr), 512'hABCD_0040);
      chk("t2_dn_txn", 512'(dn_req_txnid), 512'h33);
      chk("t2_busy", 512'(busy), 512'd1);
      chk("t2_miss_rdy", 512'(miss_rdy), 512'd0);
      @(negedge clk);
    end
    miss_vld = 1'b0;
    chk("t2_still_req", 512'(dn_req_vld), 512'd1);
    dn_req_rdy = 1'b1;
    @(negedge clk);
    chk("t2_req_done", 512'(dn_req_vld), 512'd0);
    send_beat(b3, 1'b0);
    send_beat(b2, 1'b0);
    send_beat(b1, 1'b0);
    send_beat(b0, 1'b1);
    finish_good("t2", {b0, b1, b2, b3}, 1'b0, 6'h01, 8'h33);

    // Early last on beat 1, then held response
    issue_miss(32'h0000_2000, 8'h44, 1'b1);
    @(negedge clk);
    send_beat(b0, 1'b0);
    send_beat(b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("t3_no_wr", 512'(data_wr_en), 512'd0);
      chk("t3_rsp_vld", 512'(up_rsp_vld), 512'd1);
      chk("t3_rsp_err", 512'(up_rsp_err), 512'd1);
      chk("t3_rsp_txn", 512'(up_rsp_txnid), 512'h44);
      chk("t3_rsp_data", up_rsp_data, {256'd0, b1, b0});
      chk("t3_miss_rdy", 512'(miss_rdy), 512'd0);
      @(negedge clk);
    end
    up_rsp_rdy = 1'b1;
    @(negedge clk);
    up_rsp_rdy = 1'b0;
    chk("t3_idle_rdy", 512'(miss_rdy), 512'd1);
    chk("t3_idle_vld", 512'(up_rsp_vld), 512'd0);

    // Missing last on the final slot
    issue_miss(32'h0000_3FC0, 8'h21, 1'b0);
    @(negedge clk);
    send_beat(b0, 1'b0);
    send_beat(b1, 1'b0);
    send_beat(b2, 1'b0);
    send_beat(b3, 1'b0);
    chk("t4_no_wr", 512'(data_wr_en), 512'd0);
    chk("t4_rsp_vld", 512'(up_rsp_vld), 512'd1);
    chk("t4_rsp_err", 512'(up_rsp_err), 512'd1);
    chk("t4_rsp_data", up_rsp_data, {b3, b2, b1, b0});
    send_beat(bj, 1'b1);
    chk("t4_stray_data", up_rsp_data, {b3, b2, b1, b0});
    up_rsp_rdy = 1'b1;
    @(negedge clk);
    up_rsp_rdy = 1'b0;
    chk("t4_idle_rdy", 512'(miss_rdy), 512'd1);

    // Asynchronous reset during FILL
    issue_miss(32'h0000_5540, 8'h66, 1'b1);
    @(negedge clk);
    send_beat(b0, 1'b0);
    send_beat(b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("t5_busy", 512'(busy), 512'd0);
    chk("t5_miss_rdy", 512'(miss_rdy), 512'd1);
    chk("t5_dn_addr", 512'(dn_req_addr), 512'd0);
    chk("t5_dn_txn", 512'(dn_req_txnid), 512'd0);
    chk("t5_wr_way", 512'(data_wr_way), 512'd0);
    chk("t5_line", data_wr_data, 512'd0);
    chk("t5_up_err", 512'(up_rsp_err), 512'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_no_rsp", 512'(up_rsp_vld), 512'd0);
    issue_miss(32'h0000_0FC0, 8'h99, 1'b0);
    @(negedge clk);
    send_beat(b2, 1'b0);
    send_beat(b0, 1'b0);
    send_beat(b3, 1'b0);
    send_beat(b1, 1'b1);
    finish_good("t5", {b1, b3, b0, b2}, 1'b0, 6'h3F, 8'h99);

    // Stray beats in IDLE and REQ are ignored
    send_beat(bj, 1'b1);
    chk("t6_idle_rdy", 512'(miss_rdy), 512'd1);
    chk("t6_idle_vld", 512'(up_rsp_vld), 512'd0);
    dn_req_rdy = 1'b0;
    issue_miss(32'hFFFF_FFFF, 8'hC3, 1'b1);
    send_beat(bj, 1'b1);
    chk("t6_req_vld", 512'(dn_req_vld), 512'd1);
    chk("t6_req_addr", 512'(dn_req_addr), 512'hFFFF_FFC0);
    dn_req_rdy = 1'b1;
    @(negedge clk);
    send_beat(b1, 1'b0);
    send_beat(b1, 1'b0);
    send_beat(b2, 1'b0);
    send_beat(b0, 1'b1);
    finish_good("t6", {b0, b2, b1, b1}, 1'b1, 6'h3F, 8'hC3);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/icache_miss_ctrl.md
# icache_miss_ctrl

Miss handler that sits directly downstream of the icache tag-array controller. It accepts one tag miss (address, txnid, victim way from the LRU pick), issues a line-aligned read downstream, and assembles the multi-beat refill. It then writes the full line into the data array for the victim way and returns the line to the requester. Only one miss is outstanding at a time; while a miss is in flight, `busy` stalls the tag pipeline.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, request address width
- `TXNID_WIDTH`, 8, transaction id width (matches `ICACHE_REQ_TXNID_WIDTH`)
- `INDEX_WIDTH`, 6, set index width
- `LINE_WIDTH`, 512, cache line bits; `OFFSET_WIDTH` = log2(`LINE_WIDTH`/8) = 6
- `BEAT_WIDTH`, 128, refill beat bits; `BEATS` = `LINE_WIDTH`/`BEAT_WIDTH` = 4
- `WAY_NUM`, 2, ways; way select is one bit

Ports:
- `clk` in 1: single clock, all logic on the rising edge
- `rst` in 1: asynchronous, active-high reset
- `miss_vld` in 1: tag stage reports a miss
- `miss_rdy` out 1: miss accepted when `miss_vld && miss_rdy`
- `miss_addr` in `ADDR_WIDTH`: missing request address
- `miss_txnid` in `TXNID_WIDTH`: requester txnid
- `miss_way` in 1: victim way (LRU pick)
- `dn_req_vld` out 1 / `dn_req_rdy` in 1: downstream read request handshake
- `dn_req_addr` out `ADDR_WIDTH`: line-aligned address (low `OFFSET_WIDTH` bits zero)
- `dn_req_txnid` out `TXNID_WIDTH`: captured txnid
- `dn_rsp_vld` in 1: refill beat valid; no backpressure
- `dn_rsp_data` in `BEAT_WIDTH`: refill beat, beat 0 carries the lowest line bits
- `dn_rsp_last` in 1: final beat marker
- `data_wr_en` out 1: one-cycle data-array write strobe
- `data_wr_way` out 1, `data_wr_index` out `INDEX_WIDTH`, `data_wr_data` out `LINE_WIDTH`: write target and line
- `up_rsp_vld` out 1 / `up_rsp_rdy` in 1: response handshake to the requester
- `up_rsp_txnid` out `TXNID_WIDTH`, `up_rsp_data` out `LINE_WIDTH`, `up_rsp_err` out 1: response payload
- `busy` out 1: a miss is in flight (stall to the tag stage)

## Operation
- FSM states: IDLE, REQ, FILL, WRITE, RESP.
- IDLE:
  - `miss_rdy`=1.
  - On acceptance, capture addr, txnid and way; clear the beat counter, error flag and line buffer; go to REQ.
- REQ:
  - `dn_req_vld`=1 with stable address and txnid until `dn_req_rdy`, then go to FILL.
- FILL:
  - Each `dn_rsp_vld` beat is written to line-buffer slot `cnt`, and `cnt` increments (2 bits, `BEATS`-1 max).
  - Beat `cnt`=`BEATS`-1 with `last`=1 goes to WRITE.
  - Early `last` (`cnt`<`BEATS`-1) sets the error flag and goes to RESP. The data array is not written.
  - Beat `cnt`=`BEATS`-1 with `last`=0 sets the error flag and goes to RESP. No counter wrap occurs.
- WRITE:
  - `data_wr_en`=1 for exactly one cycle with way = captured way, index = `addr[OFFSET_WIDTH+:INDEX_WIDTH]`, data = line buffer.
  - Then go to RESP.
- RESP:
  - `up_rsp_vld`=1, payload held stable until `up_rsp_rdy`, then go to IDLE.
  - `up_rsp_err` = error flag; `up_rsp_data` = line buffer (unwritten slots are zero on error).
- `dn_rsp_vld` outside FILL is ignored; no state change.
- `miss_vld` outside IDLE is not accepted (`miss_rdy`=0).
- `busy` = (state != IDLE).

## Timing
- Reset values:
  - state IDLE, `miss_rdy`=1, `busy`=0.
  - `dn_req_vld`=0, `data_wr_en`=0, `up_rsp_vld`=0, `up_rsp_err`=0.
  - All address, txnid, way and data outputs 0.
- Reset asserted mid-operation returns to IDLE immediately. The captured miss is dropped; no write and no response are produced.
- Miss accepted at cycle N gives `dn_req_vld`=1 at N+1. If `dn_req_rdy` is already high, FILL starts at N+2.
- A beat in FILL at cycle N is visible in the buffer at N+1. Back-to-back beats every cycle are supported.
- Final good beat at cycle M gives `data_wr_en` at M+1 and `up_rsp_vld` at M+2.
- Response handshake at cycle K gives `miss_rdy`=1 at K+1.
- Minimum miss-to-miss spacing, with zero-wait downstream: 1 (accept) + 1 (REQ) + `BEATS` + 1 (WRITE) + 1 (RESP) = 8 cycles.
- All outputs are registered or decoded from state only. No combinational path from `*_rdy` inputs to `*_vld` outputs.

## Test plan
- Reset, then miss addr=0x0000_1234, txnid=0x5A, way=1, `dn_req_rdy`=1, four beats 0x…11/0x…22/0x…33/0x…44 (`last` on beat 3):
  - `dn_req_addr`=0x0000_1200.
  - `data_wr_en` one cycle with way=1, index=0x08, line = {beat3, beat2, beat1, beat0}.
  - `up_rsp_txnid`=0x5A, `up_rsp_err`=0.
- `dn_req_rdy` held low 5 cycles:
  - `dn_req_vld` and address stay stable all 5 cycles.
  - `busy`=1, `miss_rdy`=0.
  - A second `miss_vld` during this time is not accepted.
- `last` asserted on beat 1:
  - No `data_wr_en`.
  - `up_rsp_err`=1 with beats 0-1 present and upper half zero.
  - Return to IDLE after handshake.
- `up_rsp_rdy` low 3 cycles:
  - Response held stable.
  - `miss_rdy` rises exactly 1 cycle after the handshake.
- `rst` pulsed during FILL after 2 beats:
  - All outputs return to reset values.
  - A subsequent miss completes normally with a fresh beat counter.
- Stray `dn_rsp_vld` in IDLE, then a normal miss:
  - The stray beat is ignored.
  - Line data equals only the FILL beats.
